// File: rtl/uart_tx_pkg.sv
// Shared definitions for the parameterised UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  // Wide enough to index up to 9 data bits
  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit holding FIFO: power-of-two depth, show-ahead read so a pop and
// its data are available on the same edge.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged on the registered count, so a pop cannot make room
  // for a push on the same edge.
  assign do_push  = push && (count_reg != FULL_CNT);
  assign do_pop   = pop && (count_reg != '0);
  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with configurable data width, parity, stop bits and baud
// divisor; frames are fed from a small holding FIFO.
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIVW       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DWIDTH-1:0]             p_data,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic                          parity_en,
  input  logic                          parity_type,
  input  logic                          stop2,
  input  logic [DIVW-1:0]               baud_div,
  output logic                          s_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DWIDTH - 1);

  state_t                state_reg;
  logic [DIVW-1:0]       baud_cnt_reg;
  logic [DIVW-1:0]       div_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt_reg;
  logic [DWIDTH-1:0]     shift_reg;
  logic [DWIDTH-1:0]     fifo_data;
  logic                  parity_en_reg;
  logic                  parity_bit_reg;
  logic                  stop2_reg;
  logic                  s_data_reg;
  logic                  busy_reg;
  logic                  push;
  logic                  pop;
  logic                  bit_done;
  logic                  frame_end;
  logic                  line_bit;

  assign data_ready = (fifo_count != FULL_CNT);
  assign push       = data_valid && data_ready;
  assign bit_done   = (baud_cnt_reg == '0);
  assign frame_end  = bit_done &&
                      (((state_reg == STOP1) && !stop2_reg) || (state_reg == STOP2));
  // Pop either from idle or on the last stop edge so frames chain without a gap
  assign pop        = (fifo_count != '0) && ((state_reg == IDLE) || frame_end);
  assign s_data     = s_data_reg;
  assign busy       = busy_reg;

  uart_tx_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (p_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count)
  );

  always_comb begin
    line_bit = 1'b1;
    case (state_reg)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shift_reg[0];
      PARITY:  line_bit = parity_bit_reg;
      default: line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      baud_cnt_reg   <= '0;
      div_reg        <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_en_reg  <= 1'b0;
      parity_bit_reg <= 1'b0;
      stop2_reg      <= 1'b0;
      s_data_reg     <= 1'b1;
      busy_reg       <= 1'b0;
    end else begin
      s_data_reg <= line_bit;
      busy_reg   <= (state_reg != IDLE) || (fifo_count != '0);
      if (pop) begin
        // Snapshot word and configuration; they stay fixed for the whole frame
        shift_reg      <= fifo_data;
        parity_en_reg  <= parity_en;
        parity_bit_reg <= (^fifo_data) ^ parity_type;
        stop2_reg      <= stop2;
        div_reg        <= baud_div;
        baud_cnt_reg   <= baud_div;
        bit_cnt_reg    <= '0;
        state_reg      <= START;
      end else if (frame_end) begin
        state_reg <= IDLE;
      end else if (state_reg != IDLE) begin
        if (!bit_done) begin
          baud_cnt_reg <= baud_cnt_reg - DIVW'(1);
        end else begin
          baud_cnt_reg <= div_reg;
          case (state_reg)
            START:  state_reg <= DATA;
            DATA: begin
              if (bit_cnt_reg == LAST_BIT) begin
                state_reg <= parity_en_reg ? PARITY : STOP1;
              end else begin
                shift_reg   <= shift_reg >> 1;
                bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
              end
            end
            PARITY: state_reg <= STOP1;
            STOP1:  state_reg <= STOP2;
            default: state_reg <= state_reg;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench: expected frames are queued when words are pushed and a
// line monitor compares every bit period of each emitted frame.
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  p_data;
  logic        data_valid;
  logic        data_ready;
  logic        parity_en;
  logic        parity_type;
  logic        stop2;
  logic [15:0] baud_div;
  logic        s_data;
  logic        busy;
  logic [2:0]  fifo_count;

  logic [4:0]  p_data5;
  logic        data_valid5;
  logic        data_ready5;
  logic        parity_en5;
  logic        parity_type5;
  logic        stop2_5;
  logic [15:0] baud_div5;
  logic        s_data5;
  logic        busy5;
  logic [2:0]  fifo_count5;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          period;
  } frame_t;

  frame_t exp_q[$];
  int     start_q[$];
  bit     mon_busy = 1'b0;

  uart_tx_param #(.DWIDTH(8), .FIFO_DEPTH(4), .DIVW(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .stop2       (stop2),
    .baud_div    (baud_div),
    .s_data      (s_data),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  uart_tx_param #(.DWIDTH(5), .FIFO_DEPTH(4), .DIVW(16)) u_dut5 (
    .clk         (clk),
    .rst         (rst),
    .p_data      (p_data5),
    .data_valid  (data_valid5),
    .data_ready  (data_ready5),
    .parity_en   (parity_en5),
    .parity_type (parity_type5),
    .stop2       (stop2_5),
    .baud_div    (baud_div5),
    .s_data      (s_data5),
    .busy        (busy5),
    .fifo_count  (fifo_count5)
  );

  function automatic frame_t make_frame(input logic [7:0] w, input int dw, input logic pen,
                                        input logic ptype, input logic s2, input int div);
    frame_t f;
    logic   par;
    int     n;
    f.bits = '0;
    par    = ptype;
    n      = 1;
    for (int i = 0; i < dw; i++) begin
      f.bits[n] = w[i];
      par       = par ^ w[i];
      n++;
    end
    if (pen) begin
      f.bits[n] = par;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (s2) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits  = n;
    f.period = div + 1;
    return f;
  endfunction

  // Line monitor: pops one expectation per start bit and checks every cycle
  initial begin : monitor
    frame_t      e;
    logic [15:0] obs;
    bit          bad;
    bit          ab;
    int          k;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && s_data === 1'b0) begin
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start seen at cycle %0d, required no frame", cyc);
          k = 0;
          while (s_data === 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
          end
        end else begin
          mon_busy = 1'b1;
          e   = exp_q.pop_front();
          obs = '0;
          bad = 1'b0;
          ab  = 1'b0;
          for (int b = 0; b < e.nbits && !ab; b++) begin
            for (int p = 0; p < e.period && !ab; p++) begin
              if (b != 0 || p != 0) @(negedge clk);
              if (rst === 1'b1) ab = 1'b1;
              else if (p == 0) obs[b] = s_data;
              else if (s_data !== obs[b]) bad = 1'b1;
            end
          end
          if (!ab) begin
            checks++;
            if (bad || obs !== e.bits) begin
              errors++;
              $display("FAIL frame: got bits %b (unstable=%0d), required %b", obs, bad, e.bits);
            end else begin
              $display("frame ok: start cycle %0d bits %b period %0d", start_q[$], obs, e.period);
            end
          end else begin
            $display("frame aborted by reset at cycle %0d", cyc);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic push_word(input logic [7:0] w, output int edge_n);
    int k;
    p_data     = w;
    data_valid = 1'b1;
    k          = 0;
    while (data_ready !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: data_ready stayed %b, required 1", data_ready);
    end
    @(posedge clk);
    #1;
    edge_n     = cyc;
    data_valid = 1'b0;
    $display("push 0x%02h accepted at edge %0d", w, edge_n);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || mon_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL wait_idle: pending=%0d busy=%b, required empty and idle", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (s_data !== 1'b1) begin errors++; $display("FAIL reset_s_data: got %b required 1", s_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", data_ready); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
    if (s_data5 !== 1'b1) begin errors++; $display("FAIL reset_s_data5: got %b required 1", s_data5); end
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_a5();
    int n;
    parity_en = 1'b1; parity_type = 1'b0; stop2 = 1'b0; baud_div = 16'd3;
    exp_q.push_back(make_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 3));
    push_word(8'hA5, n);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_data !== 1'b1) begin errors++; $display("FAIL latency_n1: s_data %b at edge N+1, required 1", s_data); end
    @(negedge clk);
    checks++;
    if (s_data !== 1'b0) begin errors++; $display("FAIL latency_n2: s_data %b at edge N+2, required 0", s_data); end
    repeat (43) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_hold: busy %b at edge N+45, required 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: busy %b at edge N+46, required 0", busy); end
    wait_idle();
  endtask

  task automatic test_3c();
    int n;
    parity_en = 1'b1; parity_type = 1'b1; stop2 = 1'b1; baud_div = 16'd0;
    exp_q.push_back(make_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 0));
    push_word(8'h3C, n);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [6];
    int         acc [6];
    w[0] = 8'h11; w[1] = 8'h82; w[2] = 8'h4D; w[3] = 8'hF0; w[4] = 8'h07; w[5] = 8'hE9;
    parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; baud_div = 16'd1;
    start_q.delete();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(make_frame(w[i], 8, 1'b0, 1'b0, 1'b0, 1));
      push_word(w[i], acc[i]);
      if (i == 1) begin
        checks++;
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL push_pop_same_edge: count %0d required 1", fifo_count); end
      end
      if (i == 4) begin
        checks += 3;
        if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: count %0d required 4", fifo_count); end
        if (data_ready !== 1'b0) begin errors++; $display("FAIL full_ready: data_ready %b required 0", data_ready); end
        if (acc[4] != acc[0] + 4) begin errors++; $display("FAIL no_stall: 5th accepted at %0d required %0d", acc[4], acc[0] + 4); end
      end
    end
    checks++;
    if (acc[5] != acc[0] + 22) begin
      errors++;
      $display("FAIL refill_after_pop: 6th accepted at %0d required %0d", acc[5], acc[0] + 22);
    end
    wait_idle();
    checks++;
    if (start_q.size() != 6) begin
      errors++;
      $display("FAIL frame_count: got %0d frames required 6", start_q.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (start_q[i] - start_q[i-1] != 20) begin
          errors++;
          $display("FAIL no_gap: frame %0d spacing %0d required 20", i, start_q[i] - start_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_midframe_cfg();
    int n;
    parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; baud_div = 16'd1;
    start_q.delete();
    exp_q.push_back(make_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1));
    push_word(8'h5A, n);
    push_word(8'hC3, n);
    repeat (4) @(negedge clk);
    parity_en = 1'b1; baud_div = 16'd2;
    exp_q.push_back(make_frame(8'hC3, 8, 1'b1, 1'b0, 1'b0, 2));
    wait_idle();
    checks++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != 20) begin
      errors++;
      $display("FAIL cfg_frame_len: %0d frames, first spacing not 20, required old config for frame 1",
               start_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    int lows;
    int bsy;
    parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; baud_div = 16'd3;
    exp_q.push_back(make_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 3));
    exp_q.push_back(make_frame(8'h21, 8, 1'b0, 1'b0, 1'b0, 3));
    exp_q.push_back(make_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 3));
    push_word(8'h96, n);
    push_word(8'h21, n);
    push_word(8'h7E, n);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks += 4;
    if (s_data !== 1'b1) begin errors++; $display("FAIL abort_s_data: got %b required 1", s_data); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL abort_count: got %0d required 0", fifo_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    if (data_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", data_ready); end
    rst = 1'b0;
    exp_q.delete();
    lows = 0;
    bsy  = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (s_data !== 1'b1) lows++;
      if (busy !== 1'b0) bsy++;
    end
    checks++;
    if (lows != 0 || bsy != 0) begin
      errors++;
      $display("FAIL quiet_after_reset: %0d low cycles, %0d busy cycles, required 0 and 0", lows, bsy);
    end
    exp_q.push_back(make_frame(8'hB4, 8, 1'b0, 1'b0, 1'b0, 3));
    push_word(8'hB4, n);
    wait_idle();
  endtask

  task automatic test_dwidth5();
    int         n;
    logic [6:0] obs;
    logic [6:0] req;
    req = 7'b1111110;
    p_data5     = 5'h1F;
    data_valid5 = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    data_valid5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_data5 !== 1'b1) begin errors++; $display("FAIL dw5_latency: s_data %b at edge N+1, required 1", s_data5); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      obs[i] = s_data5;
      if (i == 6) begin
        checks++;
        if (busy5 !== 1'b1) begin errors++; $display("FAIL dw5_busy_hold: got %b required 1", busy5); end
      end
    end
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL dw5_frame: got %b required %b", obs, req);
    end else begin
      $display("frame ok: DWIDTH=5 word 0x1F accepted at edge %0d bits %b", n, obs);
    end
    @(negedge clk);
    checks++;
    if (busy5 !== 1'b0) begin errors++; $display("FAIL dw5_busy_fall: got %b required 0", busy5); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    p_data = '0; data_valid = 1'b0;
    parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; baud_div = '0;
    p_data5 = '0; data_valid5 = 1'b0;
    parity_en5 = 1'b0; parity_type5 = 1'b0; stop2_5 = 1'b0; baud_div5 = '0;
    test_reset();
    test_a5();
    test_3c();
    test_back_to_back();
    test_midframe_cfg();
    test_reset_midframe();
    test_dwidth5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
